// File: rtl/l1_flatten.sv
// Purpose: interleave the two pooled layer-1 maps (K0, K1) element by element into the layer-2 flatten memory.
// Latency: done pulses 4N+1 cycles after start is sampled; one element pair per 4 cycles, no gaps.
// Backpressure: none; the memory bus is owned from start to done and answers combinationally, so the block never stalls.
module l1_flatten #(
    parameter int         N      = 1024,
    parameter logic [2:0] SEL_K0 = 3'd3,
    parameter logic [2:0] SEL_K1 = 3'd4,
    parameter logic [2:0] SEL_L2 = 3'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic [2:0]  csel
);

    // Sequencer states: two reads then two writes per element pair.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_WR0  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [10:0] K_LAST = 11'(N - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [10:0] k;
    logic [10:0] k_nxt;
    logic        last_elem;
    logic [19:0] a_dat;
    logic [19:0] b_dat;

    assign last_elem = (k == K_LAST);

    // Next state: start only matters in IDLE; the WR1 decision closes the element loop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_RD0 : S_IDLE;
            S_RD0:   state_nxt = S_RD1;
            S_RD1:   state_nxt = S_WR0;
            S_WR0:   state_nxt = S_WR1;
            S_WR1:   state_nxt = last_elem ? S_DONE : S_RD0;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next element index: cleared on every launch, advanced when leaving WR1 for the next pair.
    always_comb begin
        k_nxt = k;
        if (state == S_IDLE) begin
            k_nxt = 11'd0;
        end else if (state == S_WR1 && !last_elem) begin
            k_nxt = k + 11'd1;
        end
    end

    // State and element counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            k     <= 11'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Capture the K0 word at the end of RD0 and the K1 word at the end of RD1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_dat <= 20'd0;
            b_dat <= 20'd0;
        end else begin
            if (state == S_RD0) begin
                a_dat <= cdata_rd;
            end
            if (state == S_RD1) begin
                b_dat <= cdata_rd;
            end
        end
    end

    // Registered bus outputs, loaded on the edge that enters each state; decoding the
    // next state keeps crd and cwr mutually exclusive by construction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= 12'd0;
            caddr_wr <= 12'd0;
            cdata_wr <= 20'd0;
            csel     <= 3'd0;
        end else begin
            case (state_nxt)
                S_RD0: begin
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    crd      <= 1'b1;
                    cwr      <= 1'b0;
                    csel     <= SEL_K0;
                    caddr_rd <= {1'b0, k_nxt};
                end
                S_RD1: begin
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    crd      <= 1'b1;
                    cwr      <= 1'b0;
                    csel     <= SEL_K1;
                    caddr_rd <= {1'b0, k_nxt};
                end
                S_WR0: begin
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    crd      <= 1'b0;
                    cwr      <= 1'b1;
                    csel     <= SEL_L2;
                    caddr_wr <= {k_nxt, 1'b0};
                    cdata_wr <= a_dat;
                end
                S_WR1: begin
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    crd      <= 1'b0;
                    cwr      <= 1'b1;
                    csel     <= SEL_L2;
                    caddr_wr <= {k_nxt, 1'b1};
                    cdata_wr <= b_dat;
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    crd  <= 1'b0;
                    cwr  <= 1'b0;
                end
                default: begin
                    // IDLE: release the bus but leave csel where it was.
                    busy <= 1'b0;
                    done <= 1'b0;
                    crd  <= 1'b0;
                    cwr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_flatten.sv
// Purpose: directed bench for l1_flatten with behavioural K0/K1/L2 memories on the shared bus.
// Latency: checks the 4N+1 start-to-done latency and per-cycle bus protocol.
// Backpressure: not applicable; memories answer combinationally.
module tb_l1_flatten;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    logic [19:0] k0 [0:1023];
    logic [19:0] k1 [0:1023];
    logic [19:0] l2 [0:2047];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int nwr   = 0;
    int ndone = 0;
    int rd_n  = 0;
    int wa_exp = 0;

    l1_flatten dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter; stable when sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational read port of the two layer-1 memories.
    always_comb begin
        cdata_rd = 20'h0;
        if (crd) begin
            if (csel == 3'd3)      cdata_rd = k0[caddr_rd[9:0]];
            else if (csel == 3'd4) cdata_rd = k1[caddr_rd[9:0]];
        end
    end

    // Layer-2 memory write port.
    always @(posedge clk) begin
        if (reset && cwr) l2[caddr_wr[10:0]] <= cdata_wr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Bus protocol monitor: exclusivity, select codes and address sequencing.
    always @(negedge clk) begin
        if (!reset) begin
            rd_n   = 0;
            wa_exp = 0;
        end else begin
            chk("rd_wr_excl", 64'(crd & cwr), 64'd0);
            if (crd) begin
                chk("rd_sel", 64'(csel), (rd_n % 2 == 1) ? 64'd4 : 64'd3);
                chk("rd_addr", 64'(caddr_rd), 64'(rd_n / 2));
                rd_n = (rd_n + 1) % 2048;
            end
            if (cwr) begin
                chk("wr_sel", 64'(csel), 64'd5);
                chk("wr_addr", 64'(caddr_wr), 64'(wa_exp));
                wa_exp = (wa_exp + 1) % 2048;
                nwr++;
            end
            if (done) ndone++;
        end
    end

    function automatic logic [19:0] exp_l2(input int mode, input int addr);
        int kk;
        kk = addr / 2;
        if (mode == 2 && addr == 0)    return 20'h7FFFF;
        if (mode == 2 && addr == 1)    return 20'h80000;
        if (mode == 2 && addr == 2046) return 20'hFFFFF;
        if (mode == 0) return (addr % 2 == 1) ? (20'h80000 | 20'(kk)) : 20'(kk);
        return (addr % 2 == 1) ? (20'hC0000 + 20'(kk)) : (20'h30000 + 20'(kk));
    endfunction

    task automatic load_mem(input int mode);
        for (int i = 0; i < 1024; i++) begin
            if (mode == 0) begin
                k0[i] = 20'(i);
                k1[i] = 20'h80000 | 20'(i);
            end else begin
                k0[i] = 20'h30000 + 20'(i);
                k1[i] = 20'hC0000 + 20'(i);
            end
        end
        if (mode == 2) begin
            k0[0]    = 20'h7FFFF;
            k1[0]    = 20'h80000;
            k0[1023] = 20'hFFFFF;
        end
    endtask

    task automatic check_l2(input string tag, input int mode);
        for (int a = 0; a < 2048; a++) chk(tag, 64'(l2[a]), 64'(exp_l2(mode, a)));
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(output int s_cyc);
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int mode);
        int s;
        int snap;
        bit ok;
        snap = nwr;
        pulse_start(s);
        wait_done(5000, ok);
        if (!ok) chk({tag, "_timeout"}, 64'd0, 64'd1);
        chk({tag, "_lat"}, 64'(cyc - s), 64'd4097);
        chk({tag, "_nwr"}, 64'(nwr - snap), 64'd2048);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_l2({tag, "_data"}, mode);
    endtask

    initial begin
        int  s;
        int  s2;
        int  snap;
        int  hold_end;
        int  nd0;
        bit  ok;
        bit  found;

        reset = 1'b0;
        start = 1'b0;
        load_mem(0);
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'd0);
        reset = 1'b1;

        // Idle after reset: everything stays at zero.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outs", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'd0);
        end

        // Basic pass with a stray pulse at cycle 100 and start held high from cycle 200.
        snap = nwr;
        pulse_start(s);
        repeat (98) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        start = 1'b1;
        hold_end = cyc + 5000;
        wait_done(5000, ok);
        if (!ok) chk("p1_timeout", 64'd0, 64'd1);
        chk("p1_lat", 64'(cyc - s), 64'd4097);
        chk("p1_nwr", 64'(nwr - snap), 64'd2048);
        check_l2("p1_data", 0);
        chk("p1_first", 64'(l2[1]), 64'h80000);
        @(negedge clk);
        chk("p2_idle_busy", 64'(busy), 64'd0);
        s2 = cyc;
        snap = nwr;
        @(negedge clk);
        chk("p2_launch", 64'({busy, crd, caddr_rd, csel}), 64'({1'b1, 1'b1, 12'd0, 3'd3}));
        while (cyc < hold_end) @(negedge clk);
        start = 1'b0;
        wait_done(5000, ok);
        if (!ok) chk("p2_timeout", 64'd0, 64'd1);
        chk("p2_lat", 64'(cyc - s2), 64'd4097);
        chk("p2_nwr", 64'(nwr - snap), 64'd2048);
        repeat (3) @(negedge clk);
        chk("p2_no_retrigger", 64'(busy), 64'd0);

        // Mid-run asynchronous reset at element 500, then a clean full pass.
        load_mem(1);
        pulse_start(s);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (crd && caddr_rd == 12'd500) begin
                found = 1'b1;
                break;
            end
        end
        chk("mr_reached_k500", 64'(found), 64'd1);
        nd0 = ndone;
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("mr_outs", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_no_done", 64'(ndone - nd0), 64'd0);
        chk("mr_idle", 64'({busy, crd, cwr}), 64'd0);
        run_pass("mr_pass", 1);

        // Signed extremes pass through bit-exact.
        load_mem(2);
        run_pass("ext_pass", 2);
        chk("ext_l2_0", 64'(l2[0]), 64'h7FFFF);
        chk("ext_l2_1", 64'(l2[1]), 64'h80000);
        chk("ext_l2_2046", 64'(l2[2046]), 64'hFFFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/l1_flatten.md
# l1_flatten

- Downstream stage of the convolution/max-pool block.
- Once both kernels' pooled 32x32 layer-1 maps are in their result memories, this block reads them and interleaves them element by element into the 2048-entry layer-2 (flatten) memory.
- It drives the same shared result-memory bus as the convolution block: one `csel` selects the memory for both reads and writes.
- It takes ownership of the bus only between `start` and `done`.

## Interface
Parameters:
- `N`, 1024: elements per layer-1 map.
- `SEL_K0`, 3'd3: `csel` code for kernel-0 layer-1 memory.
- `SEL_K1`, 3'd4: `csel` code for kernel-1 layer-1 memory.
- `SEL_L2`, 3'd5: `csel` code for layer-2 memory.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request from the convolution stage.
- `busy` output 1: high while the block owns the memory bus.
- `done` output 1: one-cycle pulse when the flatten completes.
- `crd` output 1: memory read enable.
- `caddr_rd` output 12: read address.
- `cdata_rd` input 20: read data, combinational from `csel`/`caddr_rd` while `crd`=1; sampled at the end of the same cycle.
- `cwr` output 1: memory write enable.
- `caddr_wr` output 12: write address.
- `cdata_wr` output 20: write data.
- `csel` output 3: memory select for both read and write.

## Operation
- Reset (`reset`=0, asynchronous): `busy`=0, `done`=0, `crd`=0, `cwr`=0, `caddr_rd`=0, `caddr_wr`=0, `cdata_wr`=0, `csel`=0. The FSM goes to IDLE and the element counter k=0.
- All outputs are registered. Each state's outputs are loaded on the edge that enters that state.
- States: IDLE, RD0, RD1, WR0, WR1, DONE.
- IDLE:
  - All enables are 0; `csel` holds its last value.
  - `start`=1 sampled -> RD0, k=0, `busy`=1.
  - `start` is ignored in every other state.
- RD0: `crd`=1, `cwr`=0, `csel`=`SEL_K0`, `caddr_rd`=k. At the end of the cycle, `cdata_rd` is captured into register A. -> RD1.
- RD1: `crd`=1, `csel`=`SEL_K1`, `caddr_rd`=k. `cdata_rd` is captured into register B. -> WR0.
- WR0: `crd`=0, `cwr`=1, `csel`=`SEL_L2`, `caddr_wr`=2k, `cdata_wr`=A. -> WR1.
- WR1: `cwr`=1, `csel`=`SEL_L2`, `caddr_wr`=2k+1, `cdata_wr`=B.
  - If k=N-1 -> DONE.
  - Otherwise -> RD0 with k+1.
- DONE: `cwr`=0, `crd`=0, `busy`=0, `done`=1 for exactly one cycle. -> IDLE.
- Data handling:
  - Data is passed through unmodified as 20-bit signed values; no rounding or clamping.
  - `cwr` and `crd` are never both 1 in the same cycle.
- Address widths:
  - k is an 11-bit counter (0..N-1).
  - `caddr_wr` is `{k, 1'b0}` or `{k, 1'b1}` zero-extended to 12 bits; the maximum write address is 2047.
  - `caddr_rd` is k zero-extended to 12 bits.
- Reset mid-operation: abort immediately, with outputs to their reset values. No `done` is produced. The layer-2 contents already written stay as they are; a new `start` restarts from k=0.
- `start` held high through DONE does not re-trigger until the FSM is in IDLE. In IDLE, a high `start` launches a new pass the next cycle.

## Timing
- `start` sampled at edge t: at edge t+1, `busy`=1 and RD0 outputs for k=0 are presented.
- Element k occupies cycles t+1+4k .. t+4+4k, in order RD0, RD1, WR0, WR1.
- The last write (address 2047) is presented in cycle t+4N. `done`=1 and `busy`=0 are presented in cycle t+4N+1.
- Total latency from `start` to `done` is 4N+1 cycles: 4097 for N=1024.
- Throughput: one element pair per 4 cycles, with no idle cycles between elements.

## Test plan
- Basic interleave:
  - Stimulus: K0[k]=k, K1[k]=0x80000|k; pulse `start`.
  - Required: L2[2k]=k and L2[2k+1]=0x80000|k for all k.
  - Required: exactly 2048 writes; `done` exactly 4097 cycles after `start`.
- Signed extremes:
  - Stimulus: K0[0]=0x7FFFF, K1[0]=0x80000, K0[1023]=0xFFFFF.
  - Required: L2[0]=0x7FFFF, L2[1]=0x80000, L2[2046]=0xFFFFF, bit-exact.
- Bus protocol:
  - Required every cycle: `crd`&`cwr`=0.
  - Required: `csel`=3 on every read of K0, 4 on every read of K1, 5 on every write.
  - Required: `caddr_wr` strictly increments 0..2047.
- Spurious start:
  - Stimulus: pulse `start` at cycle 100 of a run, then hold `start` high for 5000 cycles.
  - Required: the first pass is unaffected; a second pass begins the cycle after IDLE is re-entered.
- Mid-run reset:
  - Stimulus: assert `reset`=0 asynchronously mid-cycle at k=500.
  - Required: all outputs reach their reset values before the next edge; no `done`.
  - Stimulus: after release, pulse `start`. Required: a full correct pass.
- Reset values: after power-up reset, with no `start`, all outputs stay 0 for 100 cycles.
